// File: rtl/tusca_multizona_fd.sv
// tusca_multizona_fd: round-robin multi-zone climate datapath (temperature level, fan PWM, humidity relay).
// Optional macro TUSCA_FALHA_SEGURA_EN: a faulted zone forces its fan on and its relay off.
module tusca_multizona_fd #(
   parameter int N_ZONAS         = 4,
   parameter int LARG            = 16,
   parameter int N_NIVEIS        = 8,
   parameter int PERIODO_PWM     = 2000,
   parameter int PERIODO_AMOSTRA = 100_000_000,
   parameter int TIMEOUT         = 50_000_000,
   parameter int HIST            = 2,
   localparam int ZW = (N_ZONAS > 1) ? $clog2(N_ZONAS) : 1,
   localparam int LN = $clog2(N_NIVEIS)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  habilita,
   output logic                  medir,
   output logic [ZW-1:0]         zona_medir,
   input  logic                  medida_valida,
   input  logic                  medida_erro,
   input  logic [LARG-1:0]       medida_temp,
   input  logic [LARG-1:0]       medida_umid,
   input  logic                  cfg_escreve,
   input  logic [3:0]            cfg_endereco,
   input  logic [LARG-1:0]       cfg_dado,
   output logic [N_ZONAS*LN-1:0] nivel,
   output logic [N_ZONAS-1:0]    pwm_ventoinha,
   output logic [N_ZONAS-1:0]    rele,
   output logic [N_ZONAS-1:0]    erro_zona,
   output logic                  pronto_ciclo,
   output logic [2:0]            db_estado
);

   localparam int CMAX = (TIMEOUT > PERIODO_AMOSTRA) ? TIMEOUT : PERIODO_AMOSTRA;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int PW   = (PERIODO_PWM > 1) ? $clog2(PERIODO_PWM) : 1;

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      ESPERA   = 3'd1,
      SOLICITA = 3'd2,
      AGUARDA  = 3'd3,
      ARMAZENA = 3'd4,
      PROXIMA  = 3'd5
   } estado_t;

   estado_t               estado;
   logic [ZW-1:0]         zona;
   logic [CW-1:0]         contador;
   logic [PW-1:0]         cont_pwm;
   logic [LARG-1:0]       temp_lat;
   logic [LARG-1:0]       umid_lat;
   logic [LARG-1:0]       lim_temp [0:N_NIVEIS-2];
   logic [LARG-1:0]       lim_umid;
   logic [N_ZONAS*LN-1:0] nivel_r;
   logic [N_ZONAS-1:0]    rele_r;
   logic [N_ZONAS-1:0]    pwm_bruto;
   logic [LN-1:0]         nivel_novo;
   logic [LARG:0]         soma_umid;
   logic [LARG:0]         dif_umid;
   logic [LARG-1:0]       lim_sup;
   logic [LARG-1:0]       lim_inf;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < N_NIVEIS-1; i++) lim_temp[i] <= LARG'(20 + 2*i);
         lim_umid <= LARG'(60);
      end else if (cfg_escreve) begin
         for (int i = 0; i < N_NIVEIS-1; i++)
            if (cfg_endereco == 4'(i)) lim_temp[i] <= cfg_dado;
         if (cfg_endereco == 4'd15) lim_umid <= cfg_dado;
      end
   end

   // Thresholds need not be ordered, so the level is a plain count of thresholds reached.
   always_comb begin
      nivel_novo = '0;
      for (int i = 0; i < N_NIVEIS-1; i++)
         if (temp_lat >= lim_temp[i]) nivel_novo = nivel_novo + 1'b1;
   end

   // Hysteresis bounds use one extra bit so they saturate instead of wrapping.
   assign soma_umid = {1'b0, lim_umid} + (LARG+1)'(HIST);
   assign dif_umid  = {1'b0, lim_umid} - (LARG+1)'(HIST);
   assign lim_sup   = soma_umid[LARG] ? '1 : soma_umid[LARG-1:0];
   assign lim_inf   = dif_umid[LARG]  ? '0 : dif_umid[LARG-1:0];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                cont_pwm <= '0;
      else if (cont_pwm == PW'(PERIODO_PWM - 1)) cont_pwm <= '0;
      else                                       cont_pwm <= cont_pwm + 1'b1;
   end

   always_comb begin
      pwm_bruto = '0;
      for (int z = 0; z < N_ZONAS; z++)
         pwm_bruto[z] = 32'(cont_pwm) < (32'(nivel_r[z*LN +: LN]) * PERIODO_PWM) / (N_NIVEIS - 1);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado       <= OCIOSO;
         zona         <= '0;
         contador     <= '0;
         medir        <= 1'b0;
         pronto_ciclo <= 1'b0;
         temp_lat     <= '0;
         umid_lat     <= '0;
         nivel_r      <= '0;
         rele_r       <= '0;
         erro_zona    <= '0;
      end else begin
         medir        <= 1'b0;
         pronto_ciclo <= 1'b0;
         case (estado)
            OCIOSO: begin
               if (habilita) begin
                  estado <= SOLICITA;
                  medir  <= 1'b1;
               end
            end
            ESPERA: begin
               if (!habilita) begin
                  estado   <= OCIOSO;
                  contador <= '0;
               end else if (contador == CW'(PERIODO_AMOSTRA - 1)) begin
                  estado   <= SOLICITA;
                  medir    <= 1'b1;
                  contador <= '0;
               end else begin
                  contador <= contador + 1'b1;
               end
            end
            SOLICITA: begin
               contador <= '0;
               estado   <= AGUARDA;
            end
            AGUARDA: begin
               if (medida_valida) begin
                  temp_lat <= medida_temp;
                  umid_lat <= medida_umid;
                  estado   <= ARMAZENA;
               end else if (medida_erro || contador == CW'(TIMEOUT - 1)) begin
                  for (int z = 0; z < N_ZONAS; z++)
                     if (zona == ZW'(z)) erro_zona[z] <= 1'b1;
                  estado <= PROXIMA;
               end else begin
                  contador <= contador + 1'b1;
               end
            end
            ARMAZENA: begin
               for (int z = 0; z < N_ZONAS; z++) begin
                  if (zona == ZW'(z)) begin
                     nivel_r[z*LN +: LN] <= nivel_novo;
                     if (umid_lat > lim_sup)      rele_r[z] <= 1'b1;
                     else if (umid_lat < lim_inf) rele_r[z] <= 1'b0;
                     erro_zona[z] <= 1'b0;
                  end
               end
               estado <= PROXIMA;
            end
            PROXIMA: begin
               contador <= '0;
               if (zona == ZW'(N_ZONAS - 1)) begin
                  zona         <= '0;
                  pronto_ciclo <= 1'b1;
                  estado       <= habilita ? ESPERA : OCIOSO;
               end else begin
                  zona   <= zona + 1'b1;
                  estado <= SOLICITA;
                  medir  <= 1'b1;
               end
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

`ifdef TUSCA_FALHA_SEGURA_EN
   assign pwm_ventoinha = pwm_bruto | erro_zona;
   assign rele          = rele_r & ~erro_zona;
`else
   assign pwm_ventoinha = pwm_bruto;
   assign rele          = rele_r;
`endif

   assign nivel      = nivel_r;
   assign zona_medir = zona;
   assign db_estado  = estado;

endmodule

// File: tb/tb_tusca_multizona_fd.sv
// Scoreboard bench for tusca_multizona_fd: a reference model predicts each zone update,
// the prediction is queued when the sample is driven and compared when the DUT updates.
`timescale 1ns/1ps
module tb_tusca_multizona_fd;
   localparam int NZ = 2, LG = 16, NN = 4, PP = 10, PA = 100, TO = 20, HS = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        habilita = 1'b0;
   logic        medir;
   logic [0:0]  zona_medir;
   logic        medida_valida = 1'b0;
   logic        medida_erro = 1'b0;
   logic [15:0] medida_temp = '0;
   logic [15:0] medida_umid = '0;
   logic        cfg_escreve = 1'b0;
   logic [3:0]  cfg_endereco = '0;
   logic [15:0] cfg_dado = '0;
   logic [3:0]  nivel;
   logic [1:0]  pwm_ventoinha;
   logic [1:0]  rele;
   logic [1:0]  erro_zona;
   logic        pronto_ciclo;
   logic [2:0]  db_estado;

   typedef struct { int zona; int niv; logic rel; logic err; } esperado_t;
   esperado_t fila[$];
   int checks = 0;
   int failures = 0;
   int lim_t[3];
   int lim_u;
   int niv_m[2];
   bit rel_m[2];
   bit err_m[2];

   tusca_multizona_fd #(
      .N_ZONAS(NZ), .LARG(LG), .N_NIVEIS(NN), .PERIODO_PWM(PP),
      .PERIODO_AMOSTRA(PA), .TIMEOUT(TO), .HIST(HS)
   ) dut (
      .clock(clock), .reset(reset), .habilita(habilita), .medir(medir), .zona_medir(zona_medir),
      .medida_valida(medida_valida), .medida_erro(medida_erro), .medida_temp(medida_temp),
      .medida_umid(medida_umid), .cfg_escreve(cfg_escreve), .cfg_endereco(cfg_endereco),
      .cfg_dado(cfg_dado), .nivel(nivel), .pwm_ventoinha(pwm_ventoinha), .rele(rele),
      .erro_zona(erro_zona), .pronto_ciclo(pronto_ciclo), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish, required completion before 500000ns");
      $fatal(1, "[TB] watchdog");
   end

   function automatic void modelo_reset();
      for (int i = 0; i < 3; i++) lim_t[i] = 20 + 2*i;
      lim_u = 60;
      for (int z = 0; z < 2; z++) begin
         niv_m[z] = 0;
         rel_m[z] = 1'b0;
         err_m[z] = 1'b0;
      end
   endfunction

   function automatic void modelo_amostra(int z, int t, int u);
      int c = 0;
      int sup;
      int inf;
      for (int i = 0; i < 3; i++) if (t >= lim_t[i]) c++;
      sup = (lim_u + HS > 65535) ? 65535 : lim_u + HS;
      inf = (lim_u - HS < 0) ? 0 : lim_u - HS;
      niv_m[z] = c;
      if (u > sup)      rel_m[z] = 1'b1;
      else if (u < inf) rel_m[z] = 1'b0;
      err_m[z] = 1'b0;
   endfunction

   function automatic void modelo_cfg(int a, int v);
      if (a < 3)        lim_t[a] = v;
      else if (a == 15) lim_u = v;
   endfunction

   function automatic logic rele_saida(int z);
`ifdef TUSCA_FALHA_SEGURA_EN
      return err_m[z] ? 1'b0 : rel_m[z];
`else
      return rel_m[z];
`endif
   endfunction

   function automatic int pwm_alto(int z);
`ifdef TUSCA_FALHA_SEGURA_EN
      if (err_m[z]) return PP;
`endif
      return niv_m[z] * PP / (NN - 1);
   endfunction

   function automatic logic [3:0] nivel_esperado();
      return {2'(niv_m[1]), 2'(niv_m[0])};
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      habilita = 1'b0;
      modelo_reset();
      repeat (3) @(negedge clock);
      checks++;
      if (medir !== 1'b0 || pronto_ciclo !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulsos medir=%b pronto=%b required 0 0", medir, pronto_ciclo);
      end
      checks++;
      if (nivel !== 4'd0 || rele !== 2'b00 || erro_zona !== 2'b00) begin
         failures++;
         $display("FAIL reset_saidas nivel=%h rele=%b erro=%b required 0 0 0", nivel, rele, erro_zona);
      end
      checks++;
      if (pwm_ventoinha !== 2'b00) begin
         failures++;
         $display("FAIL reset_pwm pwm=%b required 00", pwm_ventoinha);
      end
      checks++;
      if (db_estado !== 3'd0 || zona_medir !== 1'b0) begin
         failures++;
         $display("FAIL reset_estado estado=%0d zona=%0d required 0 0", db_estado, zona_medir);
      end
      reset = 1'b1;
      repeat (3) @(negedge clock);
      checks++;
      if (db_estado !== 3'd0 || medir !== 1'b0) begin
         failures++;
         $display("FAIL ocioso_sem_habilita estado=%0d medir=%b required 0 0", db_estado, medir);
      end
   endtask

   task automatic test_primeira_solicitacao();
      habilita = 1'b1;
      @(negedge clock);
      checks++;
      if (medir !== 1'b1 || zona_medir !== 1'b0 || db_estado !== 3'd2) begin
         failures++;
         $display("FAIL primeira_solicitacao medir=%b zona=%0d estado=%0d required 1 0 2",
                  medir, zona_medir, db_estado);
      end
   endtask

   task automatic aguarda_medir();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (medir !== 1'b1 && n < 300);
      checks++;
      if (medir !== 1'b1) begin
         failures++;
         $display("FAIL aguarda_medir medir=%b after %0d clocks required 1", medir, n);
      end
   endtask

   task automatic cfg_write(int a, int v);
      cfg_escreve  = 1'b1;
      cfg_endereco = 4'(a);
      cfg_dado     = 16'(v);
      modelo_cfg(a, v);
      @(negedge clock);
      cfg_escreve = 1'b0;
   endtask

   // Called on the clock where medir is high for zone z.
   task automatic test_responde(int z, bit valido, bit com_erro, int t, int u, bit cfg_en, int cfg_a, int cfg_v);
      esperado_t e;
      int n = 0;
      checks++;
      if (zona_medir !== 1'(z)) begin
         failures++;
         $display("FAIL zona_medir got=%0d required %0d", zona_medir, z);
      end
      @(negedge clock);
      checks++;
      if (medir !== 1'b0 || db_estado !== 3'd3) begin
         failures++;
         $display("FAIL aguarda medir=%b estado=%0d required 0 3", medir, db_estado);
      end
      if (valido) begin
         modelo_amostra(z, t, u);
         fila.push_back('{z, niv_m[z], rele_saida(z), err_m[z]});
         medida_valida = 1'b1;
         medida_erro   = com_erro;
         medida_temp   = 16'(t);
         medida_umid   = 16'(u);
         @(negedge clock);
         medida_valida = 1'b0;
         medida_erro   = 1'b0;
         if (cfg_en) begin
            cfg_escreve  = 1'b1;
            cfg_endereco = 4'(cfg_a);
            cfg_dado     = 16'(cfg_v);
            modelo_cfg(cfg_a, cfg_v);
         end
         @(negedge clock);
         cfg_escreve = 1'b0;
      end else begin
         err_m[z] = 1'b1;
         fila.push_back('{z, niv_m[z], rele_saida(z), err_m[z]});
         while (erro_zona[z] !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
         end
         checks++;
         if (n !== TO) begin
            failures++;
            $display("FAIL timeout_latencia got=%0d clocks required %0d", n, TO);
         end
      end
      e = fila.pop_front();
      checks++;
      if (nivel[2*e.zona +: 2] !== 2'(e.niv)) begin
         failures++;
         $display("FAIL nivel_zona%0d got=%0d required %0d", e.zona, nivel[2*e.zona +: 2], e.niv);
      end
      checks++;
      if (rele[e.zona] !== e.rel) begin
         failures++;
         $display("FAIL rele_zona%0d got=%b required %b", e.zona, rele[e.zona], e.rel);
      end
      checks++;
      if (erro_zona[e.zona] !== e.err) begin
         failures++;
         $display("FAIL erro_zona%0d got=%b required %b", e.zona, erro_zona[e.zona], e.err);
      end
   endtask

   // Called right after the last zone updates; returns on the clock where the next medir is high.
   task automatic test_espera_rodada(bit desliga);
      int n = 0;
      int alto0 = 0;
      int alto1 = 0;
      @(negedge clock);
      checks++;
      if (pronto_ciclo !== 1'b1 || db_estado !== 3'd1) begin
         failures++;
         $display("FAIL pronto_ciclo pronto=%b estado=%0d required 1 1", pronto_ciclo, db_estado);
      end
      if (desliga) begin
         habilita = 1'b0;
         @(negedge clock);
         checks++;
         if (db_estado !== 3'd0 || pronto_ciclo !== 1'b0) begin
            failures++;
            $display("FAIL espera_desliga estado=%0d pronto=%b required 0 0", db_estado, pronto_ciclo);
         end
         habilita = 1'b1;
         @(negedge clock);
         checks++;
         if (medir !== 1'b1 || db_estado !== 3'd2) begin
            failures++;
            $display("FAIL religa medir=%b estado=%0d required 1 2", medir, db_estado);
         end
      end else begin
         do begin
            @(negedge clock);
            n++;
            if (n <= PP) begin
               alto0 += pwm_ventoinha[0] ? 1 : 0;
               alto1 += pwm_ventoinha[1] ? 1 : 0;
            end
            if (n == 1) begin
               checks++;
               if (pronto_ciclo !== 1'b0) begin
                  failures++;
                  $display("FAIL pronto_largura pronto=%b required 0", pronto_ciclo);
               end
            end
            if (n == 50) begin
               medida_valida = 1'b1;
               medida_temp   = 16'd0;
               medida_umid   = 16'd0;
            end
            if (n == 51) medida_valida = 1'b0;
            if (n == 55) begin
               checks++;
               if (nivel !== nivel_esperado() || db_estado !== 3'd1) begin
                  failures++;
                  $display("FAIL medida_fora_aguarda nivel=%h estado=%0d required %h 1",
                           nivel, db_estado, nivel_esperado());
               end
            end
         end while (medir !== 1'b1 && n < 300);
         checks++;
         if (n !== PA) begin
            failures++;
            $display("FAIL periodo_amostra got=%0d clocks required %0d", n, PA);
         end
         checks++;
         if (alto0 !== pwm_alto(0) || alto1 !== pwm_alto(1)) begin
            failures++;
            $display("FAIL pwm_duty got=%0d,%0d required %0d,%0d", alto0, alto1, pwm_alto(0), pwm_alto(1));
         end
      end
   endtask

   task automatic test_reset_meio();
      reset = 1'b0;
      modelo_reset();
      fila.delete();
      repeat (2) @(negedge clock);
      checks++;
      if (nivel !== 4'd0 || rele !== 2'b00 || erro_zona !== 2'b00 || pwm_ventoinha !== 2'b00 ||
          db_estado !== 3'd0 || medir !== 1'b0) begin
         failures++;
         $display("FAIL reset_meio nivel=%h rele=%b erro=%b pwm=%b estado=%0d medir=%b required all 0",
                  nivel, rele, erro_zona, pwm_ventoinha, db_estado, medir);
      end
      reset = 1'b1;
      aguarda_medir();
      test_responde(0, 1, 0, 23, 61, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_primeira_solicitacao();
      // Basic levels, PWM duty and round period
      test_responde(0, 1, 0, 23, 70, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 1, 0, 25, 70, 0, 0, 0);
      test_espera_rodada(0);
      // Zone 1 never answers
      test_responde(0, 1, 0, 23, 50, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 0, 0, 0, 0, 0, 0, 0);
      test_espera_rodada(0);
      // Hysteresis walk on zone 0; zone 1 recovers with valida and erro together
      test_responde(0, 1, 0, 23, 62, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 1, 1, 25, 60, 0, 0, 0);
      test_espera_rodada(0);
      test_responde(0, 1, 0, 23, 63, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 1, 0, 25, 60, 0, 0, 0);
      test_espera_rodada(0);
      test_responde(0, 1, 0, 23, 59, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 1, 0, 25, 60, 0, 0, 0);
      test_espera_rodada(0);
      test_responde(0, 1, 0, 23, 57, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 1, 0, 21, 60, 0, 0, 0);
      test_espera_rodada(0);
      // Runtime threshold writes
      cfg_write(0, 30);
      test_responde(0, 1, 0, 23, 70, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 1, 0, 25, 60, 0, 0, 0);
      test_espera_rodada(0);
      cfg_write(1, 30);
      cfg_write(2, 30);
      cfg_write(7, 0);
      test_responde(0, 1, 0, 23, 70, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 1, 0, 25, 60, 0, 0, 0);
      test_espera_rodada(0);
      cfg_write(15, 0);
      test_responde(0, 1, 0, 23, 1, 0, 0, 0);
      aguarda_medir();
      test_responde(1, 1, 0, 23, 70, 1, 0, 0);
      test_espera_rodada(1);
      test_responde(0, 1, 0, 23, 70, 0, 0, 0);
      aguarda_medir();
      test_reset_meio();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
